// File: rtl/fu_complete_arbiter.sv
// Completion-bus arbiter: one registered holding slot per functional unit,
// round-robin selection of a held result onto the shared CDB broadcast port.
module fu_complete_arbiter #(
  parameter int NUM_FU = 6,
  parameter int PKT_W  = 64,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_squash,
  input  logic [NUM_FU-1:0]       i_fu_valid,
  input  logic [NUM_FU*PKT_W-1:0] i_fu_packet,
  output logic [NUM_FU-1:0]       o_fu_ready,
  input  logic                    i_cdb_ready,
  output logic                    o_cdb_valid,
  output logic [PKT_W-1:0]        o_cdb_packet,
  output logic [IDX_W-1:0]        o_cdb_src,
  output logic                    o_all_full,
  output logic [IDX_W:0]          o_held_count
);

  localparam int unsigned N = NUM_FU;

  logic [NUM_FU-1:0] r_held;
  logic [PKT_W-1:0]  r_slot_pkt [NUM_FU];
  logic [IDX_W-1:0]  r_rr_ptr;

  logic              w_found;
  logic [IDX_W-1:0]  w_sel;
  logic [NUM_FU-1:0] w_grant;
  logic [IDX_W-1:0]  w_next_ptr;
  logic [IDX_W:0]    w_count;

  // First held slot scanning upward from r_rr_ptr, wrapping mod NUM_FU.
  always_comb begin
    int unsigned      v_idx;
    logic [IDX_W-1:0] v_i;
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      v_idx = (32'(r_rr_ptr) + k) % N;
      v_i   = IDX_W'(v_idx);
      if (!w_found && r_held[v_i]) begin
        w_found = 1'b1;
        w_sel   = v_i;
      end
    end
  end

  always_comb begin
    o_cdb_valid  = w_found & ~i_squash;
    o_cdb_packet = o_cdb_valid ? r_slot_pkt[w_sel] : '0;
    o_cdb_src    = o_cdb_valid ? w_sel : '0;
    w_grant      = '0;
    if (o_cdb_valid && i_cdb_ready) w_grant[w_sel] = 1'b1;
    // A slot granted this cycle may be refilled at the same edge.
    o_fu_ready   = {NUM_FU{~i_squash}} & (~r_held | w_grant);
    if (w_sel == IDX_W'(N - 1)) w_next_ptr = '0;
    else                        w_next_ptr = w_sel + IDX_W'(1);
  end

  always_comb begin
    w_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_count = w_count + (IDX_W+1)'(r_held[i]);
    end
    o_held_count = w_count;
    o_all_full   = &r_held;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_held   <= '0;
      r_rr_ptr <= '0;
      for (int unsigned i = 0; i < N; i++) r_slot_pkt[i] <= '0;
    end else if (i_squash) begin
      r_held <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_grant[i]) r_held[i] <= 1'b0;
        if (i_fu_valid[i] && o_fu_ready[i]) begin
          r_held[i]     <= 1'b1;
          r_slot_pkt[i] <= i_fu_packet[i*PKT_W +: PKT_W];
        end
      end
      if (|w_grant) r_rr_ptr <= w_next_ptr;
    end
  end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Self-checking bench for fu_complete_arbiter: directed scenarios plus
// randomized traffic compared against a slot/pointer reference model.
module tb_fu_complete_arbiter;

  localparam int NF = 6;
  localparam int PW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            squash;
  logic [NF-1:0]   fu_valid;
  logic [NF*PW-1:0] fu_packet;
  logic [NF-1:0]   fu_ready;
  logic            cdb_ready;
  logic            cdb_valid;
  logic [PW-1:0]   cdb_packet;
  logic [2:0]      cdb_src;
  logic            all_full;
  logic [3:0]      held_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which slots hold a result, their contents, next priority.
  bit          m_held [NF];
  logic [63:0] m_pkt  [NF];
  int          m_ptr;

  fu_complete_arbiter #(.NUM_FU(NF), .PKT_W(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_squash(squash),
    .i_fu_valid(fu_valid), .i_fu_packet(fu_packet), .o_fu_ready(fu_ready),
    .i_cdb_ready(cdb_ready), .o_cdb_valid(cdb_valid), .o_cdb_packet(cdb_packet),
    .o_cdb_src(cdb_src), .o_all_full(all_full), .o_held_count(held_count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NF; i++) begin m_held[i] = 0; m_pkt[i] = '0; end
    m_ptr = 0;
  endtask

  task automatic model_sel(output int s, output bit f);
    s = 0; f = 0;
    for (int k = 0; k < NF; k++) begin
      if (!f && m_held[(m_ptr + k) % NF]) begin f = 1; s = (m_ptr + k) % NF; end
    end
  endtask

  task automatic set_pkt(input int i, input logic [63:0] v);
    fu_packet[i*PW +: PW] = v;
  endtask

  // Advance the model with the inputs present before the edge, then clock.
  task automatic tick();
    int s; bit f; bit g [NF]; bit old [NF];
    if (!rst_n) model_clear();
    else if (squash) begin
      for (int i = 0; i < NF; i++) m_held[i] = 0;
    end else begin
      model_sel(s, f);
      old = m_held;
      for (int i = 0; i < NF; i++) g[i] = 0;
      if (f && cdb_ready) begin g[s] = 1; m_held[s] = 0; m_ptr = (s + 1) % NF; end
      for (int i = 0; i < NF; i++)
        if (fu_valid[i] && (!old[i] || g[i])) begin
          m_held[i] = 1; m_pkt[i] = fu_packet[i*PW +: PW];
        end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; squash = 0; fu_valid = '0; fu_packet = '0; cdb_ready = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (cdb_valid !== 1'b0 || cdb_packet !== '0 || cdb_src !== 3'd0 || all_full !== 1'b0 || held_count !== 4'd0)
      $display("FAIL reset_outputs: valid=%b pkt=%h src=%0d full=%b cnt=%0d required all zero",
               cdb_valid, cdb_packet, cdb_src, all_full, held_count);
    else n_pass++;
    fu_valid = 6'b000111;
    for (int i = 0; i < 3; i++) set_pkt(i, 64'h100 + 64'(i));
    tick();
    fu_valid = '0;
    n_checks++;
    if (held_count !== 4'd3) $display("FAIL reset_preload: held_count=%0d required 3", held_count);
    else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++;
    if (cdb_valid !== 1'b0 || held_count !== 4'd0)
      $display("FAIL reset_async: valid=%b cnt=%0d required 0 0", cdb_valid, held_count);
    else n_pass++;
    model_clear();
    #1 rst_n = 1'b1; #1;
    n_checks++;
    if (fu_ready !== 6'b111111) $display("FAIL reset_ready: fu_ready=%b required 111111", fu_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_single();
    fu_valid = 6'b000100; set_pkt(2, 64'hA5); cdb_ready = 1;
    tick();
    fu_valid = '0;
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 3'd2 || cdb_packet !== 64'hA5)
      $display("FAIL single_bcast: valid=%b src=%0d pkt=%h required 1 2 a5", cdb_valid, cdb_src, cdb_packet);
    else n_pass++;
    tick();
    n_checks++;
    if (cdb_valid !== 1'b0) $display("FAIL single_idle: valid=%b required 0", cdb_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    fu_valid = '1; cdb_ready = 1;
    for (int i = 0; i < NF; i++) set_pkt(i, 64'hC000 + 64'(i));
    tick();
    fu_valid = '0;
    for (int c = 0; c < NF; c++) begin
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 3'(c) || cdb_packet !== 64'hC000 + 64'(c)
          || held_count !== 4'(NF - c) || all_full !== (c == 0))
        $display("FAIL rr_cycle%0d: valid=%b src=%0d pkt=%h cnt=%0d full=%b required src %0d cnt %0d",
                 c, cdb_valid, cdb_src, cdb_packet, held_count, all_full, c, NF - c);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (cdb_valid !== 1'b0 || held_count !== 4'd0)
      $display("FAIL rr_drain: valid=%b cnt=%0d required 0 0", cdb_valid, held_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    fu_valid = 6'b010000; set_pkt(4, 64'hB1); cdb_ready = 0;
    tick();
    set_pkt(4, 64'hB2);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 3'd4 || cdb_packet !== 64'hB1 || fu_ready[4] !== 1'b0)
        $display("FAIL bp_stall%0d: valid=%b src=%0d pkt=%h rdy4=%b required 1 4 b1 0",
                 c, cdb_valid, cdb_src, cdb_packet, fu_ready[4]);
      else n_pass++;
      tick();
    end
    cdb_ready = 1; #1;
    n_checks++;
    if (fu_ready[4] !== 1'b1 || cdb_packet !== 64'hB1)
      $display("FAIL bp_release: rdy4=%b pkt=%h required 1 b1", fu_ready[4], cdb_packet);
    else n_pass++;
    tick();
    fu_valid = '0;
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 3'd4 || cdb_packet !== 64'hB2)
      $display("FAIL bp_second: valid=%b src=%0d pkt=%h required 1 4 b2", cdb_valid, cdb_src, cdb_packet);
    else n_pass++;
    tick();
  endtask

  task automatic test_refill();
    fu_valid = 6'b000010; cdb_ready = 1; set_pkt(1, 64'd100);
    tick();
    for (int k = 1; k < 6; k++) begin
      set_pkt(1, 64'd100 + 64'(k)); #1;
      n_checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 3'd1 || cdb_packet !== 64'd100 + 64'(k - 1) || fu_ready[1] !== 1'b1)
        $display("FAIL refill%0d: valid=%b src=%0d pkt=%0d rdy1=%b required 1 1 %0d 1",
                 k, cdb_valid, cdb_src, cdb_packet, fu_ready[1], 100 + k - 1);
      else n_pass++;
      tick();
    end
    fu_valid = '0;
    tick();
  endtask

  task automatic test_squash();
    int ptr_before;
    cdb_ready = 0; fu_valid = 6'b001111;
    for (int i = 0; i < 4; i++) set_pkt(i, 64'hD0 + 64'(i));
    tick();
    ptr_before = m_ptr;
    squash = 1; fu_valid = 6'b000001; set_pkt(0, 64'hDEAD); #1;
    n_checks++;
    if (cdb_valid !== 1'b0 || fu_ready !== 6'b000000)
      $display("FAIL squash_comb: valid=%b fu_ready=%b required 0 000000", cdb_valid, fu_ready);
    else n_pass++;
    tick();
    squash = 0; fu_valid = '0;
    n_checks++;
    if (held_count !== 4'd0 || cdb_valid !== 1'b0)
      $display("FAIL squash_clear: cnt=%0d valid=%b required 0 0", held_count, cdb_valid);
    else n_pass++;
    fu_valid = '1; cdb_ready = 1;
    for (int i = 0; i < NF; i++) set_pkt(i, 64'hE0 + 64'(i));
    tick();
    fu_valid = '0;
    n_checks++;
    if (ptr_before != 2 || cdb_src !== 3'(ptr_before))
      $display("FAIL squash_ptr: src=%0d ptr_model=%0d required 2", cdb_src, ptr_before);
    else n_pass++;
    repeat (NF) tick();
  endtask

  task automatic test_random();
    bit pv [NF]; logic [63:0] pp [NF];
    int s; bit f; bit ev; logic [NF-1:0] erdy; int ecnt;
    for (int i = 0; i < NF; i++) pv[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      squash    = ($urandom % 16) == 0;
      cdb_ready = ($urandom % 10) < 7;
      for (int i = 0; i < NF; i++) begin
        if (!pv[i] && ($urandom % 2)) begin pv[i] = 1; pp[i] = {$urandom, $urandom}; end
        fu_valid[i] = pv[i];
        set_pkt(i, pp[i]);
      end
      model_sel(s, f);
      ev = f && !squash;
      ecnt = 0;
      for (int i = 0; i < NF; i++) begin
        ecnt += m_held[i];
        erdy[i] = !squash && (!m_held[i] || (ev && cdb_ready && s == i));
      end
      #1;
      n_checks++;
      if (cdb_valid !== ev || cdb_src !== (ev ? 3'(s) : 3'd0) || cdb_packet !== (ev ? m_pkt[s] : 64'd0))
        $display("FAIL rand_cdb c%0d: valid=%b src=%0d pkt=%h required %b %0d %h",
                 cyc, cdb_valid, cdb_src, cdb_packet, ev, ev ? s : 0, ev ? m_pkt[s] : 64'd0);
      else n_pass++;
      n_checks++;
      if (fu_ready !== erdy) $display("FAIL rand_ready c%0d: fu_ready=%b required %b", cyc, fu_ready, erdy);
      else n_pass++;
      n_checks++;
      if (held_count !== 4'(ecnt) || all_full !== (ecnt == NF))
        $display("FAIL rand_count c%0d: cnt=%0d full=%b required %0d %b", cyc, held_count, all_full, ecnt, ecnt == NF);
      else n_pass++;
      for (int i = 0; i < NF; i++) if (erdy[i]) pv[i] = 0;
      tick();
    end
    squash = 0; fu_valid = '0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_refill();
    test_squash();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
